// File: rtl/audio_codec_i2c_target.sv
// I2C target standing in for the audio codec control port: 7-bit address, 16-bit subaddress,
// byte data into a 256-entry register file at REG_BASE<<8, reads via repeated START.
module audio_codec_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h3B,
  parameter logic [7:0] REG_BASE    = 8'h40,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        reg_we,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  peek_addr,
  output logic [7:0]  peek_data,
  output logic        busy,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEVADDR, S_ACK_DEV, S_SUB_HI, S_ACK_HI, S_SUB_LO,
    S_ACK_LO, S_WDATA, S_ACK_W, S_RDATA, S_MACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] ptr_q, ptr_d;
  logic        rnw_q, rnw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_en;
  logic [7:0]  rx_byte, rd_byte, peek_d;

  logic [7:0]  mem_q [256];
  logic        reg_we_q;
  logic [15:0] reg_addr_q;
  logic [7:0]  reg_wdata_q, peek_q;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rx_byte = {shift_q, sda_s};
  assign rd_byte = (ptr_q[15:8] == REG_BASE) ? mem_q[ptr_q[7:0]] : 8'h00;

  // ACK states: first SCL fall pulls SDA, second fall releases it and moves on.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rnw_d     = rnw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_det) begin
      state_d   = S_DEVADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_DEVADDR, S_SUB_HI, S_SUB_LO, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_DEVADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = S_ACK_DEV;
                    rnw_d   = rx_byte[0];
                    tx_d    = rd_byte;
                  end else begin
                    state_d = S_IDLE;
                  end
                end
                S_SUB_HI: begin
                  ptr_d[15:8] = rx_byte;
                  state_d     = S_ACK_HI;
                end
                S_SUB_LO: begin
                  ptr_d[7:0] = rx_byte;
                  state_d    = S_ACK_LO;
                end
                default: begin
                  wr_en      = (ptr_q[15:8] == REG_BASE);
                  ptr_d[7:0] = ptr_q[7:0] + 8'd1;
                  state_d    = S_ACK_W;
                end
              endcase
            end
          end
        end
        S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_W: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              case (state_q)
                S_ACK_DEV: begin
                  if (rnw_q) begin
                    state_d  = S_RDATA;
                    sda_oe_d = ~tx_q[7];
                  end else begin
                    state_d = S_SUB_HI;
                  end
                end
                S_ACK_HI: state_d = S_SUB_LO;
                default:  state_d = S_WDATA;
              endcase
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d[7:0] = ptr_q[7:0] + 8'd1;
              state_d    = S_MACK;
            end
          end
        end
        S_MACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              state_d = S_RDATA;
              tx_d    = rd_byte;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A write landing on the peeked address this cycle is forwarded.
  assign peek_d = (wr_en && (ptr_q[7:0] == peek_addr)) ? rx_byte : mem_q[peek_addr];

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_q        <= 8'd0;
      ptr_q       <= 16'd0;
      rnw_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 16'd0;
      reg_wdata_q <= 8'd0;
      peek_q      <= 8'd0;
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rnw_q      <= rnw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      reg_we_q   <= wr_en;
      peek_q     <= peek_d;
      if (wr_en) begin
        mem_q[ptr_q[7:0]] <= rx_byte;
        reg_addr_q        <= ptr_q;
        reg_wdata_q       <= rx_byte;
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign peek_data   = peek_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_audio_codec_i2c_target.sv
// Bench for audio_codec_i2c_target: bit-level I2C master, table of write transactions,
// hand-written read / reset sequences and random bursts checked against a register-file model.
module tb_audio_codec_i2c_target;

  logic        clk_100 = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        sda_m;
  logic        sda_bus;
  logic        sda_oe;
  logic        reg_we;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  peek_addr;
  logic [7:0]  peek_data;
  logic        busy;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic oe_seen = 1'b0;

  logic [7:0]  model_mem [256];
  logic [23:0] exp_q [$];

  typedef struct {
    logic [7:0]  ab;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          n;
    logic [63:0] d;
    logic        exp_ack;
    int          exp_nwe;
  } vec_t;
  vec_t tbl [5];

  assign sda_bus = sda_m & ~sda_oe;

  audio_codec_i2c_target dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .peek_addr   (peek_addr),
    .peek_data   (peek_data),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk_100 = ~clk_100;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  // scoreboard on accepted register writes
  always @(negedge clk_100) begin
    if (rst_n && sda_oe) oe_seen = 1'b1;
    if (rst_n && reg_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_reg_we", {8'h0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("reg_write", {8'h0, reg_addr, reg_wdata}, {8'h0, exp_q.pop_front()});
      end
      if (peek_addr == reg_addr[7:0]) check("peek_forward", {24'h0, peek_data}, {24'h0, reg_wdata});
    end
  end

  // driver tasks (SCL low on entry/exit except start/idle)
  task automatic i2c_start();
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    sda_m = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(4);
    ack = ~sda_bus; wait_clk(4);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(4);
      scl = 1'b1; wait_clk(4);
      v[i] = sda_bus; wait_clk(4);
      scl = 1'b0; wait_clk(4);
    end
    send_bit(nack);
    sda_m = 1'b1;
  endtask

  // full write transaction; the model decides which bytes land in the register file
  task automatic do_write(input logic [7:0] ab, input logic [7:0] hi, input logic [7:0] lo,
                          input int n, input logic [63:0] d, input logic exp_ack, output int nwe);
    logic ack;
    logic [7:0] p;
    logic [7:0] b;
    bit target_write;
    target_write = (ab[7:1] == 7'h3B) && !ab[0];
    we_cnt = 0;
    oe_seen = 1'b0;
    p = lo;
    i2c_start();
    send_byte(ab, ack); check("ack_addr", {31'h0, ack}, {31'h0, exp_ack});
    send_byte(hi, ack); check("ack_sub_hi", {31'h0, ack}, {31'h0, exp_ack});
    send_byte(lo, ack); check("ack_sub_lo", {31'h0, ack}, {31'h0, exp_ack});
    for (int i = 0; i < n; i++) begin
      b = d[8*i +: 8];
      if (target_write && hi == 8'h40) begin
        model_mem[p] = b;
        exp_q.push_back({hi, p, b});
      end
      p = p + 8'd1;
      send_byte(b, ack); check("ack_data", {31'h0, ack}, {31'h0, exp_ack});
    end
    check("busy_before_stop", {31'h0, busy}, 32'h1);
    i2c_stop();
    wait_clk(4);
    check("busy_after_stop", {31'h0, busy}, 32'h0);
    check("exp_q_drained", exp_q.size(), 0);
    if (!exp_ack) check("oe_never_driven", {31'h0, oe_seen}, 32'h0);
    nwe = we_cnt;
  endtask

  task automatic do_read(input logic [7:0] hi, input logic [7:0] lo, input int n);
    logic ack;
    logic [7:0] v;
    logic [7:0] p;
    p = lo;
    i2c_start();
    send_byte(8'h76, ack); check("rd_ack_waddr", {31'h0, ack}, 32'h1);
    send_byte(hi, ack);    check("rd_ack_hi", {31'h0, ack}, 32'h1);
    send_byte(lo, ack);    check("rd_ack_lo", {31'h0, ack}, 32'h1);
    i2c_rstart();
    send_byte(8'h77, ack); check("rd_ack_raddr", {31'h0, ack}, 32'h1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, v);
      check("rd_data", {24'h0, v}, {24'h0, (hi == 8'h40) ? model_mem[p] : 8'h00});
      p = p + 8'd1;
    end
    wait_clk(2);
    check("rd_sda_released", {31'h0, sda_oe}, 32'h0);
    i2c_stop();
    wait_clk(4);
  endtask

  task automatic peek_check(input logic [7:0] a);
    peek_addr = a;
    wait_clk(1);
    check("peek", {24'h0, a, peek_data}, {24'h0, a, model_mem[a]});
  endtask

  initial begin
    int nwe;
    logic [7:0] rhi, rlo;
    int rn;
    logic [63:0] rd;

    tbl[0] = '{ab: 8'h76, hi: 8'h40, lo: 8'h15, n: 1, d: 64'h01, exp_ack: 1'b1, exp_nwe: 1};
    tbl[1] = '{ab: 8'h76, hi: 8'h40, lo: 8'h02, n: 6, d: 64'h0000_0120_0C00_7D00, exp_ack: 1'b1, exp_nwe: 6};
    tbl[2] = '{ab: 8'h74, hi: 8'h40, lo: 8'h10, n: 1, d: 64'h99, exp_ack: 1'b0, exp_nwe: 0};
    tbl[3] = '{ab: 8'h76, hi: 8'h40, lo: 8'hFF, n: 2, d: 64'hBBAA, exp_ack: 1'b1, exp_nwe: 2};
    tbl[4] = '{ab: 8'h76, hi: 8'h00, lo: 8'h15, n: 1, d: 64'h55, exp_ack: 1'b1, exp_nwe: 0};
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; peek_addr = 8'h15;
    wait_clk(4);
    check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_reg_we", {31'h0, reg_we}, 32'h0);
    check("rst_reg_addr", {16'h0, reg_addr}, 32'h0);
    check("rst_reg_wdata", {24'h0, reg_wdata}, 32'h0);
    check("rst_peek", {24'h0, peek_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_clk(8);

    for (int i = 0; i < 5; i++) begin
      do_write(tbl[i].ab, tbl[i].hi, tbl[i].lo, tbl[i].n, tbl[i].d, tbl[i].exp_ack, nwe);
      check("nwe", nwe, tbl[i].exp_nwe);
      wait_clk(8);
    end
    peek_check(8'h15);
    check("reg15_is_01", {24'h0, peek_data}, 32'h01);
    peek_check(8'h03);
    check("reg03_is_7d", {24'h0, peek_data}, 32'h7D);
    peek_check(8'h00);
    check("reg00_is_bb", {24'h0, peek_data}, 32'hBB);

    // write subaddress, repeated START, read 2 bytes
    do_read(8'h40, 8'h15, 2);
    do_read(8'h12, 8'h00, 1);

    // random bursts, each followed by a read-back of the same window
    for (int k = 0; k < 8; k++) begin
      rhi = ($urandom_range(0, 3) == 0) ? 8'h12 : 8'h40;
      rlo = 8'($urandom_range(0, 255));
      rn  = $urandom_range(1, 4);
      rd  = {$urandom, $urandom};
      do_write(8'h76, rhi, rlo, rn, rd, 1'b1, nwe);
      check("rnd_nwe", nwe, (rhi == 8'h40) ? rn : 0);
      wait_clk(8);
      do_read(rhi, rlo, rn);
      wait_clk(8);
    end

    // reset asserted while the device-address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i[2:0] == 3'd0 ? 1'b0 : ((8'h76 >> i) & 8'h01) != 0);
    sda_m = 1'b1; wait_clk(4);
    check("oe_in_ack_slot", {31'h0, sda_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("oe_async_reset", {31'h0, sda_oe}, 32'h0);
    check("busy_async_reset", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    exp_q.delete();
    wait_clk(2);
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    peek_check(8'h15);
    do_write(8'h76, 8'h40, 8'h20, 1, 64'h5A, 1'b1, nwe);
    check("post_reset_nwe", nwe, 1);

    for (int a = 0; a < 256; a++) peek_check(8'(a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
